// File: rtl/bcd_arb_pkg.sv
// rtl/bcd_arb_pkg.sv - shared types and constants for the BCD operation arbiter
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam logic                OP_ADD  = 1'b0;
  localparam logic                OP_SUB  = 1'b1;
  localparam int                  DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_op_arbiter_if.sv
// rtl/bcd_op_arbiter_if.sv - request, result and serial signals of the BCD operation arbiter
interface bcd_op_arbiter_if #(
  parameter int DIGITS = 4
);
  import bcd_arb_pkg::*;

  localparam int W = DIGIT_W * DIGITS;

  logic         req0_valid;
  logic         req0_ready;
  logic         req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic         req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         res_valid;
  logic         res_id;
  logic [W-1:0] res_data;
  logic         res_carry;
  logic         res_err;
  logic         ser_out;
  logic         ser_active;
  logic         busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_data, res_carry, res_err,
    input  ser_out, ser_active, busy
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_data, res_carry, res_err,
    output ser_out, ser_active, busy
  );

endinterface

// File: rtl/bcd_addsub4.sv
// rtl/bcd_addsub4.sv - combinational digit-wise BCD adder/subtractor with decimal carry chain
module bcd_addsub4
  import bcd_arb_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                      op,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                      carry,
  output logic                      err
);

  logic [DIGIT_W*DIGITS-1:0] raw;
  logic [DIGIT_W-1:0]        da;
  logic [DIGIT_W-1:0]        db;
  logic [DIGIT_W-1:0]        dbx;
  logic [DIGIT_W:0]          s;
  logic                      c;
  logic                      bad;

  // Ripple a decimal carry from the low digit up; subtract is a + nines(b) + 1.
  always_comb begin
    raw = '0;
    da  = '0;
    db  = '0;
    dbx = '0;
    s   = '0;
    bad = 1'b0;
    c   = (op == OP_SUB);
    for (int i = 0; i < DIGITS; i++) begin
      da = a[DIGIT_W*i +: DIGIT_W];
      db = b[DIGIT_W*i +: DIGIT_W];
      if ((da > BCD_MAX) || (db > BCD_MAX)) begin
        bad = 1'b1;
      end
      dbx = (op == OP_SUB) ? (BCD_MAX - db) : db;
      s   = {1'b0, da} + {1'b0, dbx} + {{DIGIT_W{1'b0}}, c};
      if (s > {1'b0, BCD_MAX}) begin
        s = s - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      raw[DIGIT_W*i +: DIGIT_W] = s[DIGIT_W-1:0];
    end
  end

  // A bad digit poisons the result; for subtract a missing final carry means borrow.
  assign err   = bad;
  assign sum   = bad ? '0 : raw;
  assign carry = bad ? 1'b0 : (c ^ (op == OP_SUB));

endmodule

// File: rtl/bcd_op_arbiter.sv
// rtl/bcd_op_arbiter.sv - two-requester round-robin BCD add/subtract unit with serial result
module bcd_op_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  bcd_op_arbiter_if.slave bus
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int CW = $clog2(W);

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           op_q;
  logic           id_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sh_q;
  logic           res_valid_q;
  logic           res_id_q;
  logic [W-1:0]   res_data_q;
  logic           res_carry_q;
  logic           res_err_q;
  logic           gnt0;
  logic           gnt1;
  logic           hs;
  logic [W-1:0]   sum;
  logic           carry;
  logic           err;

  bcd_addsub4 #(.DIGITS(DIGITS)) u_addsub (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .sum   (sum),
    .carry (carry),
    .err   (err)
  );

  // Grant in IDLE (requester not granted last wins a tie), then walk EXEC and 16 SHIFT cycles.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        gnt0 = bus.req0_valid && !gnt1;
        if (gnt0 || gnt1) begin
          state_d = EXEC;
          last_d  = gnt1;
        end
      end
      EXEC: begin
        state_d = SHIFT;
        cnt_d   = '0;
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W-1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hs = gnt0 || gnt1;

  // Control state: FSM, last-grant pointer and shift counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the granted requester's operation at the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q <= OP_ADD;
      id_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (hs) begin
      op_q <= gnt1 ? bus.req1_op : bus.req0_op;
      id_q <= gnt1;
      a_q  <= gnt1 ? bus.req1_a : bus.req0_a;
      b_q  <= gnt1 ? bus.req1_b : bus.req0_b;
    end
  end

  // Register the result at the end of EXEC and shift a copy out MSB first during SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      sh_q        <= '0;
    end else begin
      res_valid_q <= (state_q == EXEC);
      if (state_q == EXEC) begin
        res_id_q    <= id_q;
        res_data_q  <= sum;
        res_carry_q <= carry;
        res_err_q   <= err;
        sh_q        <= sum;
      end else if (state_q == SHIFT) begin
        sh_q <= {sh_q[W-2:0], 1'b0};
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_err    = res_err_q;
  assign bus.ser_active = (state_q == SHIFT);
  assign bus.ser_out    = (state_q == SHIFT) && sh_q[W-1];
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_op_arbiter.sv
// tb/tb_bcd_op_arbiter.sv - scoreboard bench for the BCD operation arbiter
module tb_bcd_op_arbiter;
  import bcd_arb_pkg::*;

  localparam int DIGITS = 4;
  localparam int PERIOD = 18;
  localparam int BOUND  = 5000;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    int          gap;
    bit          drop;
    int          hold;
  } op_t;

  typedef struct {
    logic        id;
    logic [15:0] data;
    logic        carry;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_op_arbiter_if #(.DIGITS(DIGITS)) bus ();

  bcd_op_arbiter #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  op_t  q0[$];
  op_t  q1[$];
  exp_t exp_q[$];
  int   gnt_id_log[$];
  int   gnt_cyc_log[$];

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          next_free = 0;
  bit          mlast = 1'b1;
  int          ser_k = 16;
  logic [15:0] ser_word = '0;
  logic        hd_id = 1'b0;
  logic [15:0] hd_data = '0;
  logic        hd_carry = 1'b0;
  logic        hd_err = 1'b0;
  bit          in_rst = 1'b0;
  bit          act0 = 1'b0;
  bit          act1 = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Decimal value of a 4-digit BCD word; flags any digit above nine.
  function automatic int bcd_val(input logic [15:0] x, output bit bad);
    int v;
    int d;
    v = 0;
    bad = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic id, input logic op, input logic [15:0] a,
                                 input logic [15:0] b, input int due);
    exp_t e;
    bit ba;
    bit bb;
    int va;
    int vb;
    va = bcd_val(a, ba);
    vb = bcd_val(b, bb);
    e.id  = id;
    e.due = due;
    e.err = 1'b0;
    if (ba || bb) begin
      e.err   = 1'b1;
      e.data  = '0;
      e.carry = 1'b0;
    end else if (op == OP_ADD) begin
      e.carry = (va + vb > 9999);
      e.data  = to_bcd((va + vb) % 10000);
    end else if (va >= vb) begin
      e.carry = 1'b0;
      e.data  = to_bcd(va - vb);
    end else begin
      e.carry = 1'b1;
      e.data  = to_bcd(10000 + va - vb);
    end
    return e;
  endfunction

  // Monitor: round-robin/timing model, result scoreboard and serial stream check.
  initial begin : monitor
    exp_t e;
    bit   idle;
    bit   w1;
    bit   r0;
    bit   r1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        in_rst    = 1'b1;
        exp_q.delete();
        ser_k     = 16;
        mlast     = 1'b1;
        next_free = 0;
        hd_id     = 1'b0;
        hd_data   = '0;
        hd_carry  = 1'b0;
        hd_err    = 1'b0;
      end else begin
        if (in_rst) begin
          in_rst = 1'b0;
          check("reset_state", {bus.busy, bus.res_valid, bus.res_id, bus.res_carry, bus.res_err,
                                bus.ser_out, bus.ser_active, bus.res_data}, 32'd0);
        end
        idle = (cyc >= next_free);
        w1   = bus.req1_valid && (!bus.req0_valid || !mlast);
        r1   = idle && w1;
        r0   = idle && bus.req0_valid && !w1;
        check("ready", {bus.req1_ready, bus.req0_ready}, {r1, r0});
        check("busy", bus.busy, !idle);
        if (bus.req0_ready || bus.req1_ready) begin
          gnt_id_log.push_back(int'(bus.req1_ready));
          gnt_cyc_log.push_back(cyc);
        end
        if (r0 || r1) begin
          if (r1) exp_q.push_back(model(1'b1, bus.req1_op, bus.req1_a, bus.req1_b, cyc + 2));
          else    exp_q.push_back(model(1'b0, bus.req0_op, bus.req0_a, bus.req0_b, cyc + 2));
          mlast     = r1;
          next_free = cyc + PERIOD;
        end
        if (bus.res_valid) begin
          if (exp_q.size() == 0) begin
            check("res_unexpected", bus.res_valid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("res_cycle", cyc, e.due);
            check("res_id", bus.res_id, e.id);
            check("res_data", bus.res_data, e.data);
            check("res_carry", bus.res_carry, e.carry);
            check("res_err", bus.res_err, e.err);
            hd_id    = e.id;
            hd_data  = e.data;
            hd_carry = e.carry;
            hd_err   = e.err;
            ser_word = e.data;
            ser_k    = 0;
          end
        end else begin
          check("res_hold", {bus.res_id, bus.res_carry, bus.res_err, bus.res_data},
                {hd_id, hd_carry, hd_err, hd_data});
        end
        if (ser_k < 16) begin
          check("ser_bit", {bus.ser_active, bus.ser_out}, {1'b1, ser_word[15 - ser_k]});
          ser_k++;
        end else begin
          check("ser_idle", {bus.ser_active, bus.ser_out}, 2'b00);
        end
      end
    end
  end

  // Driver: each requester holds valid until granted (or until a drop op gives up).
  initial begin : driver
    op_t c0;
    op_t c1;
    int  h0;
    int  h1;
    int  g0;
    int  g1;
    bit  hs0;
    bit  hs1;
    c0 = '{op: 1'b0, a: 16'h0, b: 16'h0, gap: 0, drop: 1'b0, hold: 0};
    c1 = c0;
    h0 = 0;
    h1 = 0;
    g0 = 0;
    g1 = 0;
    bus.req0_valid = 1'b0;
    bus.req0_op    = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req1_valid = 1'b0;
    bus.req1_op    = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    forever begin
      @(negedge clk);
      hs0 = bus.req0_valid && bus.req0_ready;
      hs1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (act0) begin
        if (hs0) act0 = 1'b0;
        else begin
          h0--;
          if (h0 <= 0) begin
            act0 = 1'b0;
            if (!c0.drop) check("req0_grant_timeout", hs0, 1'b1);
          end
        end
      end
      if (act1) begin
        if (hs1) act1 = 1'b0;
        else begin
          h1--;
          if (h1 <= 0) begin
            act1 = 1'b0;
            if (!c1.drop) check("req1_grant_timeout", hs1, 1'b1);
          end
        end
      end
      if (!act0 && q0.size() > 0) begin
        if (g0 < q0[0].gap) g0++;
        else begin
          c0 = q0.pop_front();
          act0 = 1'b1;
          h0 = c0.drop ? c0.hold : 400;
          g0 = 0;
        end
      end
      if (!act1 && q1.size() > 0) begin
        if (g1 < q1[0].gap) g1++;
        else begin
          c1 = q1.pop_front();
          act1 = 1'b1;
          h1 = c1.drop ? c1.hold : 400;
          g1 = 0;
        end
      end
      bus.req0_valid = act0;
      bus.req0_op    = c0.op;
      bus.req0_a     = c0.a;
      bus.req0_b     = c0.b;
      bus.req1_valid = act1;
      bus.req1_op    = c1.op;
      bus.req1_a     = c1.a;
      bus.req1_b     = c1.b;
    end
  end

  task automatic push(input int r, input logic op, input logic [15:0] a, input logic [15:0] b,
                      input int gap, input bit drop, input int hold);
    op_t o;
    o.op   = op;
    o.a    = a;
    o.b    = b;
    o.gap  = gap;
    o.drop = drop;
    o.hold = hold;
    if (r == 1) q1.push_back(o);
    else        q0.push_back(o);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act0 || act1 || exp_q.size() > 0 ||
            ser_k < 16 || bus.busy) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < BOUND, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_last(input string name, input logic id, input logic [15:0] data,
                            input logic carry, input logic err);
    check({name, "_id"}, bus.res_id, id);
    check({name, "_data"}, bus.res_data, data);
    check({name, "_carry"}, bus.res_carry, carry);
    check({name, "_err"}, bus.res_err, err);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(31, 0) == 0) v[4*i +: 4] = 4'($urandom_range(15, 10));
      else                            v[4*i +: 4] = 4'($urandom_range(9, 0));
    end
    return v;
  endfunction

  initial begin : main
    int n;
    int base;
    logic [15:0] ra;
    logic [15:0] rb;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    push(0, OP_ADD, 16'h1234, 16'h5678, 0, 1'b0, 0);
    wait_idle();
    check_last("add_basic", 1'b0, 16'h6912, 1'b0, 1'b0);
    push(0, OP_ADD, 16'h9999, 16'h0001, 0, 1'b0, 0);
    wait_idle();
    check_last("add_wrap", 1'b0, 16'h0000, 1'b1, 1'b0);
    push(0, OP_SUB, 16'h0100, 16'h0001, 0, 1'b0, 0);
    wait_idle();
    check_last("sub_plain", 1'b0, 16'h0099, 1'b0, 1'b0);
    push(0, OP_SUB, 16'h0001, 16'h0002, 0, 1'b0, 0);
    wait_idle();
    check_last("sub_borrow", 1'b0, 16'h9999, 1'b1, 1'b0);
    push(0, OP_ADD, 16'h00A0, 16'h0001, 0, 1'b0, 0);
    wait_idle();
    check_last("bad_digit", 1'b0, 16'h0000, 1'b0, 1'b1);

    push(0, OP_ADD, 16'h4321, 16'h1111, 0, 1'b0, 0);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_result", bus.res_valid, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    push(1, OP_SUB, 16'h5000, 16'h0001, 0, 1'b0, 0);
    wait_idle();
    check_last("post_reset_req1", 1'b1, 16'h4999, 1'b0, 1'b0);

    base = gnt_id_log.size();
    push(0, OP_ADD, 16'h0005, 16'h0005, 0, 1'b0, 0);
    push(0, OP_SUB, 16'h0500, 16'h0700, 0, 1'b0, 0);
    push(1, OP_ADD, 16'h8888, 16'h2222, 0, 1'b0, 0);
    push(1, OP_SUB, 16'h3000, 16'h2999, 0, 1'b0, 0);
    wait_idle();
    check("rr_count", gnt_id_log.size() - base, 4);
    if (gnt_id_log.size() >= base + 3) begin
      check("rr_first", gnt_id_log[base], 0);
      check("rr_second", gnt_id_log[base + 1], 1);
      check("rr_third", gnt_id_log[base + 2], 0);
      check("rr_gap1", gnt_cyc_log[base + 1] - gnt_cyc_log[base], PERIOD);
      check("rr_gap2", gnt_cyc_log[base + 2] - gnt_cyc_log[base + 1], PERIOD);
    end

    base = gnt_id_log.size();
    push(0, OP_ADD, 16'h0042, 16'h0058, 0, 1'b0, 0);
    push(1, OP_ADD, 16'h1111, 16'h1111, 3, 1'b1, 5);
    wait_idle();
    check("drop_grants", gnt_id_log.size() - base, 1);
    check("drop_last_id", bus.res_id, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = rand_bcd();
      rb = ($urandom_range(7, 0) == 0) ? ra : rand_bcd();
      push(int'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), ra, rb,
           int'($urandom_range(20, 0)), 1'b0, 0);
    end
    wait_idle();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
